// File: rtl/motor_ui_pkg.sv
// motor_ui_pkg: shared speed encoding, scan start pattern and counter sizing helper
package motor_ui_pkg;

    typedef enum logic [1:0] {SPD_0, SPD_1, SPD_2, SPD_3} speed_t;

    localparam logic [3:0] DIGIT_FIRST = 4'b0001;

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, stable-level debounce and one-cycle press pulse
module button_debouncer
    import motor_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic s1, s2, level, level_prev;
    logic [CW-1:0] cnt;

    // A level is accepted once the synchronised value has differed from it for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            s1         <= btn;
            s2         <= s1;
            level_prev <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_prev;

endmodule

// File: rtl/speed_command_encoder.sv
// speed_command_encoder: debounced up/down/stop buttons drive a saturating speed code,
// alongside a free-running one-hot digit scan for the display multiplexer.
module speed_command_encoder
    import motor_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_CYCLES     = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_stop,
    output logic [1:0] motor_speed,
    output logic [3:0] switch_enabler,
    output logic       speed_changed
);

    localparam int SW = cnt_width(SCAN_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

    logic up, down, stop;
    speed_t state, next;
    logic [SW-1:0] scan_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset(reset), .btn(btn_up), .press(up)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .reset(reset), .btn(btn_down), .press(down)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .reset(reset), .btn(btn_stop), .press(stop)
    );

    // Stop wins outright; opposing up/down presses cancel
    always_comb begin
        next = stop ? SPD_0
             : (up && !down && state != SPD_3) ? speed_t'(state + 2'd1)
             : (down && !up && state != SPD_0) ? speed_t'(state - 2'd1)
             : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SPD_0;
            speed_changed <= 1'b0;
        end else begin
            state         <= next;
            speed_changed <= next != state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt       <= '0;
            switch_enabler <= DIGIT_FIRST;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt       <= '0;
            switch_enabler <= {switch_enabler[2:0], switch_enabler[3]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign motor_speed = state;

endmodule
